adc_serial_ctrl: RTL and testbench

Parametrised successor to the fixed-function ADC control writer. It accepts register-write commands (address + data) through a valid/ready port into a small command FIFO. Each command is serialised as one 3-wire frame (sclk, sdata, active-low select) to the ADC configuration port. It sits between the board control logic (init, DES-mode switching, calibration) and the ADC serial pins, and replaces hard-wired per-mode sequences with arbitrary queued writes.

---
 rtl/adc_serial_ctrl.sv | 177 +++++++++++++++++
 tb/tb_adc_serial_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_ctrl.sv
// Queued register-write serialiser for the ADC 3-wire configuration port.
// Commands enter a small FIFO; each one is shifted out as {HDR, addr, data}, MSB first.
module adc_serial_ctrl #(
  parameter int               HDR_W      = 12,
  parameter logic [HDR_W-1:0] HDR        = 12'h001,
  parameter int               ADDR_W     = 4,
  parameter int               DATA_W     = 16,
  parameter int               CLK_DIV    = 4,
  parameter int               GAP_CYC    = 8,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            busy,
  output logic                            done,
  output logic [7:0]                      frame_cnt,
  output logic                            sclk,
  output logic                            sdata,
  output logic                            select
);

  localparam int FRAME_W = HDR_W + ADDR_W + DATA_W;
  localparam int CMD_W   = ADDR_W + DATA_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               low_q, low_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               sclk_q, sclk_d, sdata_q, sdata_d, select_q, select_d, done_q, done_d;
  logic [CMD_W-1:0]   mem_q [FIFO_DEPTH];

  logic push, pop, div_end;

  assign wr_ready = (level_q != LVL_FULL);
  assign push     = wr_valid && wr_ready;
  assign pop      = (state_q == S_IDLE) && (level_q != '0);
  assign div_end  = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    div_d       = '0;
    bit_d       = bit_q;
    low_d       = low_q;
    gap_d       = gap_q;
    shift_d     = shift_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d     = level_q + LVL_W'(push) - LVL_W'(pop);

    if (state_q != S_IDLE) div_d = div_end ? '0 : div_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = {HDR, mem_q[rd_ptr_q]};
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_end) begin
          state_d = S_SHIFT;
          bit_d   = '0;
          low_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (div_end) begin
          if (!low_q) begin
            low_d = 1'b1;
            // Data moves on the falling sclk edge; the last bit is left in place for HOLD.
            if (bit_q != BIT_LAST) shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          end else begin
            low_d = 1'b0;
            if (bit_q == BIT_LAST) state_d = S_HOLD;
            else                   bit_d   = bit_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (div_end) begin
          state_d     = S_GAP;
          gap_d       = '0;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pin values are registered from the next state so the serial lines never glitch.
    select_d = (state_d == S_IDLE) || (state_d == S_GAP);
    sclk_d   = (state_d == S_SHIFT) && !low_d;
    sdata_d  = !select_d && shift_d[FRAME_W-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      low_q       <= 1'b0;
      gap_q       <= '0;
      shift_q     <= '0;
      frame_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      select_q    <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      low_q       <= low_d;
      gap_q       <= gap_d;
      shift_q     <= shift_d;
      frame_cnt_q <= frame_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      select_q    <= select_d;
      done_q      <= done_d;
    end
  end

  // NOTE: the command storage has no reset; emptiness is tracked by the reset pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_addr, wr_data};
  end

  assign fifo_level = level_q;
  assign busy       = (state_q != S_IDLE) || (level_q != '0);
  assign done       = done_q;
  assign frame_cnt  = frame_cnt_q;
  assign sclk       = sclk_q;
  assign sdata      = sdata_q;
  assign select     = select_q;

endmodule

// File: tb/tb_adc_serial_ctrl.sv
// Directed bench for adc_serial_ctrl: a default instance and a fast CLK_DIV=1/GAP_CYC=1 instance.
// A pin monitor per instance rebuilds each frame from sclk rising edges.
module tb_adc_serial_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr_valid_a = 1'b0, wr_ready_a, busy_a, done_a, sclk_a, sdata_a, select_a;
  logic [3:0]  wr_addr_a = '0;
  logic [15:0] wr_data_a = '0;
  logic [2:0]  fifo_level_a;
  logic [7:0]  frame_cnt_a;

  logic        wr_valid_b = 1'b0, wr_ready_b, busy_b, done_b, sclk_b, sdata_b, select_b;
  logic [3:0]  wr_addr_b = '0;
  logic [15:0] wr_data_b = '0;
  logic [2:0]  fifo_level_b;
  logic [7:0]  frame_cnt_b;

  adc_serial_ctrl dut_a (
    .clk(clk), .rst(rst), .wr_valid(wr_valid_a), .wr_ready(wr_ready_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .fifo_level(fifo_level_a),
    .busy(busy_a), .done(done_a), .frame_cnt(frame_cnt_a),
    .sclk(sclk_a), .sdata(sdata_a), .select(select_a)
  );

  adc_serial_ctrl #(.CLK_DIV(1), .GAP_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .fifo_level(fifo_level_b),
    .busy(busy_b), .done(done_b), .frame_cnt(frame_cnt_b),
    .sclk(sclk_b), .sdata(sdata_b), .select(select_b)
  );

  typedef struct {
    logic [31:0] word;
    int          nbits;
    int          lowc;
    int          hi_before;
  } rec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [31:0] word;
  } vec_t;

  rec_t qa[$], qb[$];
  int n_checks = 0, n_errors = 0;

  // Pin monitors
  logic [31:0] cap_a, cap_b;
  int nbits_a, lowc_a, hic_a, last_hi_a, done_cnt_a = 0, bad_edge_a = 0;
  int nbits_b, lowc_b, hic_b, last_hi_b, done_cnt_b = 0, bad_edge_b = 0;
  logic prev_sclk_a, prev_sel_a, prev_sclk_b, prev_sel_b;

  always @(negedge clk) begin
    if (rst) begin
      cap_a = '0; nbits_a = 0; lowc_a = 0; hic_a = 0; last_hi_a = 0;
      prev_sclk_a = 1'b0; prev_sel_a = 1'b1;
    end else begin
      if (sclk_a && !prev_sclk_a) begin
        if (select_a) bad_edge_a++;
        else begin cap_a = {cap_a[30:0], sdata_a}; nbits_a++; end
      end
      if (select_a) hic_a++;
      else begin
        if (prev_sel_a) begin last_hi_a = hic_a; hic_a = 0; end
        lowc_a++;
      end
      if (done_a) begin
        qa.push_back('{cap_a, nbits_a, lowc_a, last_hi_a});
        done_cnt_a++;
        cap_a = '0; nbits_a = 0; lowc_a = 0;
      end
      prev_sclk_a = sclk_a; prev_sel_a = select_a;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      cap_b = '0; nbits_b = 0; lowc_b = 0; hic_b = 0; last_hi_b = 0;
      prev_sclk_b = 1'b0; prev_sel_b = 1'b1;
    end else begin
      if (sclk_b && !prev_sclk_b) begin
        if (select_b) bad_edge_b++;
        else begin cap_b = {cap_b[30:0], sdata_b}; nbits_b++; end
      end
      if (select_b) hic_b++;
      else begin
        if (prev_sel_b) begin last_hi_b = hic_b; hic_b = 0; end
        lowc_b++;
      end
      if (done_b) begin
        qb.push_back('{cap_b, nbits_b, lowc_b, last_hi_b});
        done_cnt_b++;
        cap_b = '0; nbits_b = 0; lowc_b = 0;
      end
      prev_sclk_b = sclk_b; prev_sel_b = select_b;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the push was accepted.
  task automatic push_a(input logic [3:0] a, input logic [15:0] d);
    int n = 0;
    while (!wr_ready_a && n < 2000) begin @(negedge clk); n++; end
    check("push_a_ready", {31'd0, wr_ready_a}, 32'd1);
    wr_valid_a = 1'b1; wr_addr_a = a; wr_data_a = d;
    @(negedge clk);
    wr_valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [3:0] a, input logic [15:0] d);
    int n = 0;
    while (!wr_ready_b && n < 2000) begin @(negedge clk); n++; end
    check("push_b_ready", {31'd0, wr_ready_b}, 32'd1);
    wr_valid_b = 1'b1; wr_addr_b = a; wr_data_b = d;
    @(negedge clk);
    wr_valid_b = 1'b0;
  endtask

  task automatic wait_idle_a(input int limit);
    int n = 0;
    while (busy_a && n < limit) begin @(negedge clk); n++; end
    check("idle_a_reached", {31'd0, busy_a}, 32'd0);
  endtask

  function automatic rec_t pop_a();
    rec_t r;
    r.word = '0; r.nbits = 0; r.lowc = 0; r.hi_before = 0;
    if (qa.size() > 0) r = qa.pop_front();
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[4];
    rec_t r;
    int n, dc, bad;
    logic [31:0] w;

    vec[0] = '{4'hA, 16'h1234, 32'h001A_1234};
    vec[1] = '{4'h0, 16'h0000, 32'h0010_0000};
    vec[2] = '{4'hF, 16'hFFFF, 32'h001F_FFFF};
    vec[3] = '{4'h5, 16'hA5C3, 32'h0015_A5C3};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_select", {31'd0, select_a}, 32'd1);
    check("rst_sclk",   {31'd0, sclk_a},   32'd0);
    check("rst_sdata",  {31'd0, sdata_a},  32'd0);
    check("rst_ready",  {31'd0, wr_ready_a}, 32'd1);
    check("rst_level",  {29'd0, fifo_level_a}, 32'd0);
    check("rst_fcnt",   {24'd0, frame_cnt_a}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_select", {31'd0, select_a}, 32'd1);
    check("idle_busy",   {31'd0, busy_a},   32'd0);
    check("idle_done",   {31'd0, done_a},   32'd0);

    // Single frames from the vector table
    for (int i = 0; i < 4; i++) begin
      push_a(vec[i].addr, vec[i].data);
      n = 0;
      while (select_a && n < 50) begin @(negedge clk); n++; end
      check("frame_start", {31'd0, select_a}, 32'd0);
      n = 0;
      while (busy_a && n < 1000) begin @(negedge clk); n++; end
      check("frame_period", n, 32'd272);
      check("frame_records", qa.size(), 32'd1);
      r = pop_a();
      check("frame_word",  r.word,  vec[i].word);
      check("frame_nbits", r.nbits, 32'd32);
      check("frame_lowc",  r.lowc,  32'd264);
      check("frame_cnt",   {24'd0, frame_cnt_a}, i + 1);
      check("done_cnt",    done_cnt_a, i + 1);
    end

    // Burst of six: FIFO fills, push refused while full, then resumes after a pop
    for (int k = 0; k < 5; k++) push_a(vec[k % 4].addr, vec[k % 4].data);
    check("burst_level_full", {29'd0, fifo_level_a}, 32'd4);
    check("burst_ready_low",  {31'd0, wr_ready_a},   32'd0);
    check("burst_busy",       {31'd0, busy_a},       32'd1);
    n = 0;
    while (!wr_ready_a && n < 1000) begin @(negedge clk); n++; end
    check("burst_level_after_pop", {29'd0, fifo_level_a}, 32'd3);
    check("burst_select_after_pop", {31'd0, select_a}, 32'd0);
    push_a(vec[1].addr, vec[1].data);
    wait_idle_a(3000);
    check("burst_records", qa.size(), 32'd6);
    for (int j = 0; j < 6; j++) begin
      r = pop_a();
      check("burst_word", r.word, vec[j % 4].word);
      if (j > 0) check("burst_gap", r.hi_before, 32'd9);
    end
    check("burst_fcnt", {24'd0, frame_cnt_a}, 32'd10);

    // Push coinciding with the IDLE pop at level 2
    for (int k = 0; k < 3; k++) push_a(vec[k].addr, vec[k].data);
    check("pp_level_queued", {29'd0, fifo_level_a}, 32'd2);
    n = 0;
    while (!done_a && n < 400) begin @(negedge clk); n++; end
    check("pp_done_seen", {31'd0, done_a}, 32'd1);
    repeat (8) @(negedge clk);
    check("pp_idle_select", {31'd0, select_a}, 32'd1);
    check("pp_idle_level",  {29'd0, fifo_level_a}, 32'd2);
    wr_valid_a = 1'b1; wr_addr_a = vec[3].addr; wr_data_a = vec[3].data;
    @(negedge clk);
    wr_valid_a = 1'b0;
    check("pp_level_kept", {29'd0, fifo_level_a}, 32'd2);
    check("pp_started",    {31'd0, select_a},     32'd0);
    wait_idle_a(3000);
    check("pp_records", qa.size(), 32'd4);
    for (int j = 0; j < 4; j++) begin
      r = pop_a();
      check("pp_word", r.word, vec[j].word);
    end
    check("pp_fcnt", {24'd0, frame_cnt_a}, 32'd14);

    // Reset in the middle of a frame with a second command queued
    push_a(vec[0].addr, vec[0].data);
    push_a(vec[1].addr, vec[1].data);
    n = 0;
    while (nbits_a < 10 && n < 500) begin @(negedge clk); n++; end
    check("mr_edges", nbits_a, 32'd10);
    dc = done_cnt_a;
    #2 rst = 1'b1;
    #1;
    check("mr_select", {31'd0, select_a}, 32'd1);
    check("mr_sclk",   {31'd0, sclk_a},   32'd0);
    check("mr_sdata",  {31'd0, sdata_a},  32'd0);
    check("mr_level",  {29'd0, fifo_level_a}, 32'd0);
    check("mr_ready",  {31'd0, wr_ready_a},   32'd1);
    check("mr_busy",   {31'd0, busy_a},       32'd0);
    check("mr_fcnt",   {24'd0, frame_cnt_a},  32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("mr_no_done",   done_cnt_a, dc);
    check("mr_no_frames", qa.size(), 32'd0);
    check("mr_idle",      {31'd0, busy_a}, 32'd0);
    push_a(vec[2].addr, vec[2].data);
    wait_idle_a(1000);
    r = pop_a();
    check("mr_new_word",  r.word,  vec[2].word);
    check("mr_new_nbits", r.nbits, 32'd32);
    check("mr_new_fcnt",  {24'd0, frame_cnt_a}, 32'd1);
    check("a_stray_edges", bad_edge_a, 32'd0);

    // 256 frames on the fast instance: frame counter wraps to zero
    for (int i = 0; i < 256; i++) push_b(4'(i), 16'(i) ^ 16'h5a5a);
    n = 0;
    while (busy_b && n < 5000) begin @(negedge clk); n++; end
    check("wrap_idle",    {31'd0, busy_b}, 32'd0);
    check("wrap_fcnt",    {24'd0, frame_cnt_b}, 32'd0);
    check("wrap_dones",   done_cnt_b, 32'd256);
    check("wrap_records", qb.size(), 32'd256);
    bad = 0;
    for (int j = 0; j < qb.size(); j++) begin
      w = {12'h001, 4'(j), 16'(j) ^ 16'h5a5a};
      if (qb[j].word !== w || qb[j].nbits != 32) bad++;
    end
    check("wrap_bad_frames", bad, 32'd0);
    if (qb.size() > 1) begin
      check("fast_lowc", qb[0].lowc, 32'd66);
      check("fast_gap",  qb[1].hi_before, 32'd2);
    end
    check("b_stray_edges", bad_edge_b, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
